// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with valid/ready handshake and MUL/DIV sequencing.
// Sits between ID/EX and the ALU; busy/in_ready feed the hazard unit.
//
// state | meaning
// IDLE  | no result pending, ready for a request
// MULTI | MUL/DIV in flight, counting down, pipeline stalled
// OUT   | result presented, waiting for out_ready
module alu_ctrl_seq #(
  parameter int FUNC_W = 6,
  parameter int CTRL_W = 4,
  parameter int MC_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [FUNC_W-1:0] func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              multi_cycle,
  output logic              illegal,
  output logic              busy
);

  localparam int CNT_W = $clog2(MC_LAT) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULTI = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CTRL_W-1:0]  alu_ctrl_q, alu_ctrl_d;
  logic               multi_cycle_q, multi_cycle_d;
  logic               illegal_q, illegal_d;

  logic [3:0]         dec_ctrl;
  logic               dec_mc;
  logic               dec_ill;
  logic               accept;
  logic               load;

  always_comb begin
    dec_ctrl = 4'b0000;
    dec_mc   = 1'b0;
    dec_ill  = 1'b0;
    case (alu_op)
      2'b00: begin
        case (func)
          FUNC_W'(0): dec_ctrl = 4'b0000;
          FUNC_W'(1): dec_ctrl = 4'b0001;
          FUNC_W'(2): dec_ctrl = 4'b0101;
          FUNC_W'(3): dec_ctrl = 4'b0110;
          FUNC_W'(4): dec_ctrl = 4'b0111;
          FUNC_W'(5): dec_ctrl = 4'b0011;
          FUNC_W'(6): dec_ctrl = 4'b0100;
          FUNC_W'(7): dec_ctrl = 4'b0010;
          FUNC_W'(8): begin
            dec_ctrl = 4'b1000;
            dec_mc   = 1'b1;
          end
          FUNC_W'(9): begin
            dec_ctrl = 4'b1001;
            dec_mc   = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      2'b01:   dec_ctrl = 4'b0001;
      2'b10:   dec_ctrl = 4'b0111;
      default: dec_ctrl = 4'b0000;
    endcase
  end

  assign in_ready = (state_q == IDLE) | ((state_q == OUT) & out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_ctrl_d    = alu_ctrl_q;
    multi_cycle_d = multi_cycle_q;
    illegal_d     = illegal_q;
    load          = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) load = 1'b1;
      end
      MULTI: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (accept) load = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new request replaces the held result; upper control bits stay zero.
    if (load) begin
      alu_ctrl_d    = CTRL_W'(dec_ctrl);
      multi_cycle_d = dec_mc;
      illegal_d     = dec_ill;
      state_d       = dec_mc ? MULTI : OUT;
      cnt_d         = dec_mc ? CNT_W'(MC_LAT - 1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      alu_ctrl_q    <= '0;
      multi_cycle_q <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_ctrl_q    <= alu_ctrl_d;
      multi_cycle_q <= multi_cycle_d;
      illegal_q     <= illegal_d;
    end
  end

  assign out_valid   = (state_q == OUT);
  assign busy        = (state_q == MULTI);
  assign alu_ctrl    = alu_ctrl_q;
  assign multi_cycle = multi_cycle_q;
  assign illegal     = illegal_q;

endmodule
